card_table_scanner: RTL and testbench
=====================================

// Module: card_table_scanner
// PURPOSE
// - GC-side consumer of card_table: walks 32-bit master card table, then the
//   32 card words of each marked 16MB region, and streams base addresses of
//   dirty 16KB cards to the collector.
// - Wishbone bus master (wb_cmd_request32_t / wb_cmd_response32_t) on the same
//   bus as card_table; output is a valid/ready address stream.
// PARAMETERS
// - MCT_ADDR   32'hFEE80000  byte address of master card table register (BAR1)
// - CARD_ADDR  32'hFEE00000  byte address of card word 0 (BAR0)
// - TIMEOUT    16'd1023      cycles to wait for ack before abort (err)
// PORTS
// - rst_i        in   1       synchronous active-high reset
// - clk_i        in   1       single clock, all logic rising edge
// - start_i      in   1       pulse: begin scan (ignored unless IDLE)
// - busy_o       out  1       scan in progress
// - done_o       out  1       one-cycle pulse at scan completion
// - err_o        out  1       sticky bus timeout/err flag, cleared by start_i
// - wbm_req      out  struct  wb_cmd_request32_t bus request
// - wbm_resp     in   struct  wb_cmd_response32_t bus response
// - card_adr_o   out  32      dirty card base address {3'b0,reg[4:0],wd[4:0],bt[4:0],14'b0}
// - card_vld_o   out  1       card_adr_o valid
// - card_rdy_i   in   1       consumer accepts card_adr_o when vld&rdy
// BEHAVIOUR
// - Reset: state IDLE; busy_o,done_o,err_o,card_vld_o=0; card_adr_o=0;
//   wbm_req all fields 0 (cyc=stb=we=0). Reset mid-scan aborts immediately, no
//   bus cycle completes after reset edge.
// - FSM: IDLE -> RD_MCT -> NEXT_REG -> RD_CARD -> EMIT -> (CLR_CARD) -> NEXT_WD
//   ... -> (CLR_MCT) -> DONE -> IDLE.
// - Bus rule: one transaction outstanding; cyc,stb,sel=4'hF,padr held stable
//   until ack; dropped the cycle after ack. cmd=CMD_LOAD for reads, CMD_STORE
//   for writes (never CMD_STOREPTR: scanner writes must not re-mark cards).
// - RD_MCT: read MCT_ADDR, latch 32-bit mask into mct_r; reg=0.
// - NEXT_REG: if mct_r[reg]==0 skip region in one cycle (reg+1); if reg wraps
//   past 31 go to CLR_MCT/DONE. Else wd=0, go RD_CARD.
// - RD_CARD: read CARD_ADDR + {reg,wd,2'b00}; latch word_r. word_r==0 ->
//   NEXT_WD directly (no EMIT cycle).
// - EMIT: priority-encode lowest set bit bt of word_r; present card_adr_o,
//   card_vld_o=1; on vld&rdy clear word_r[bt]; max one address per cycle;
//   card_adr_o/vld held stable while rdy=0. word_r==0 -> CLR_CARD or NEXT_WD.
// - NEXT_WD: wd+1; wd wraps 31->0 advances reg (to NEXT_REG).
// - Ordering: addresses ascending (reg, wd, bt). Throughput 1 addr/clk with rdy=1.
// - Timeout: ack absent TIMEOUT cycles, or wbm_resp.err=1 -> drop cyc, set err_o,
//   go DONE (done_o still pulses).
// - done_o pulses exactly once per accepted start_i; busy_o=1 from cycle after
//   start_i through DONE cycle. start_i while busy ignored.
// - Concurrent marking: cards marked after their word is read are picked up
//   on the next scan, not this one.
// CONFIGURATION
// - CARD_SCAN_CLEAR_EN defined: after EMIT of a nonzero word, CLR_CARD writes
//   32'h0 to that card word; after last region, CLR_MCT writes 32'h0 to
//   MCT_ADDR. Marks set between read and clear are lost (documented GC race).
// - Undefined: scanner is read-only; CLR_CARD/CLR_MCT states absent, we=0 always.
// TESTING
// - mct=0 -> exactly one bus read (MCT), no addresses, done_o 3-6 clks after start.
// - mct=32'h0000_0004, card word reg2/wd0=32'h8000_0001 -> addrs 32'h0200_0000,
//   32'h0207_C000 in order; done_o once.
// - Same as above with card_rdy_i toggling 1/0 -> no address dropped or
//   duplicated; card_adr_o stable while rdy=0.
// - CARD_SCAN_CLEAR_EN: after scan, reread word reg2/wd0 and MCT -> both 0;
//   no CMD_STOREPTR seen on bus.
// - Slave never acks MCT read -> err_o=1 after TIMEOUT+1 clks, done_o pulse,
//   cyc=0.
// - rst_i asserted during EMIT -> next clk busy_o=0, card_vld_o=0, cyc=0;
//   new start_i scans from region 0.

Source files
------------

// File: rtl/card_table_scanner.sv
// Card table scanner: reads the master card table, then the card words of every marked
// region, and streams dirty-card base addresses. CARD_SCAN_CLEAR_EN adds write-back clearing.
package wb32_pkg;
  typedef enum logic [1:0] {CMD_LOAD = 2'd0, CMD_STORE = 2'd1, CMD_STOREPTR = 2'd2} wb_cmd_e;
  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    wb_cmd_e     cmd;
    logic [31:0] padr;
    logic [31:0] dat;
  } wb_cmd_request32_t;
  typedef struct packed {
    logic        ack;
    logic        err;
    logic [31:0] dat;
  } wb_cmd_response32_t;
endpackage

module card_table_scanner import wb32_pkg::*; #(
  parameter logic [31:0] MCT_ADDR  = 32'hFEE80000,
  parameter logic [31:0] CARD_ADDR = 32'hFEE00000,
  parameter logic [15:0] TIMEOUT   = 16'd1023
) (
  input  logic               rst_i,
  input  logic               clk_i,
  input  logic               start_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output wb_cmd_request32_t  wbm_req,
  input  wb_cmd_response32_t wbm_resp,
  output logic [31:0]        card_adr_o,
  output logic               card_vld_o,
  input  logic               card_rdy_i
);
  typedef enum logic [3:0] {
    S_IDLE, S_RD_MCT, S_NEXT_REG, S_RD_CARD, S_EMIT, S_NEXT_WD, S_DONE
`ifdef CARD_SCAN_CLEAR_EN
    , S_CLR_CARD, S_CLR_MCT
`endif
  } state_t;

  state_t            r_state;
  wb_cmd_request32_t r_req;
  logic [31:0]       r_mct, r_word, r_adr;
  logic [4:0]        r_region, r_wd;
  logic [15:0]       r_timer;
  logic              r_busy, r_done, r_err, r_vld;

  logic              w_bus;
  logic [31:0]       w_pe_in, w_pe_rest, w_card_adr;
  logic [4:0]        w_bt;

  function automatic wb_cmd_request32_t bus_rd(input logic [31:0] a);
    bus_rd      = '0;
    bus_rd.cyc  = 1'b1;
    bus_rd.stb  = 1'b1;
    bus_rd.sel  = 4'hF;
    bus_rd.cmd  = CMD_LOAD;
    bus_rd.padr = a;
  endfunction

`ifdef CARD_SCAN_CLEAR_EN
  // Plain store: a pointer store here would re-mark the card we are clearing.
  function automatic wb_cmd_request32_t bus_wr(input logic [31:0] a);
    bus_wr      = bus_rd(a);
    bus_wr.we   = 1'b1;
    bus_wr.cmd  = CMD_STORE;
  endfunction
`endif

  function automatic logic [31:0] card_word_adr(input logic [4:0] rg, input logic [4:0] wd);
    card_word_adr = CARD_ADDR + {20'd0, rg, wd, 2'b00};
  endfunction

  always_comb begin
    w_bus = (r_state == S_RD_MCT) || (r_state == S_RD_CARD);
`ifdef CARD_SCAN_CLEAR_EN
    w_bus = w_bus || (r_state == S_CLR_CARD) || (r_state == S_CLR_MCT);
`endif
  end

  // The encoder sees the fresh bus word in RD_CARD so the first address costs no extra cycle.
  assign w_pe_in = (r_state == S_RD_CARD) ? wbm_resp.dat : r_word;

  always_comb begin
    w_bt = '0;
    for (int i = 31; i >= 0; i--) begin
      if (w_pe_in[i]) w_bt = i[4:0];
    end
  end

  assign w_pe_rest  = w_pe_in & ~(32'd1 << w_bt);
  assign w_card_adr = {3'b000, r_region, r_wd, w_bt, 14'd0};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_req    <= '0;
      r_mct    <= '0;
      r_word   <= '0;
      r_adr    <= '0;
      r_region <= '0;
      r_wd     <= '0;
      r_timer  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_vld    <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_timer <= (w_bus && !wbm_resp.ack) ? r_timer + 16'd1 : 16'd0;
      if (w_bus && (wbm_resp.err || (!wbm_resp.ack && r_timer == TIMEOUT - 16'd1))) begin
        r_req   <= '0;
        r_err   <= 1'b1;
        r_done  <= 1'b1;
        r_state <= S_DONE;
      end else begin
        case (r_state)
          S_IDLE: if (start_i) begin
            r_busy  <= 1'b1;
            r_err   <= 1'b0;
            r_req   <= bus_rd(MCT_ADDR);
            r_state <= S_RD_MCT;
          end
          S_RD_MCT: if (wbm_resp.ack) begin
            r_req    <= '0;
            r_mct    <= wbm_resp.dat;
            r_region <= '0;
            // Empty master table: nothing to walk and nothing to clear.
            if (wbm_resp.dat == 32'd0) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_NEXT_REG;
            end
          end
          S_NEXT_REG: begin
            if (r_mct[r_region]) begin
              r_wd    <= '0;
              r_req   <= bus_rd(card_word_adr(r_region, 5'd0));
              r_state <= S_RD_CARD;
            end else if (r_region == 5'd31) begin
`ifdef CARD_SCAN_CLEAR_EN
              r_req   <= bus_wr(MCT_ADDR);
              r_state <= S_CLR_MCT;
`else
              r_done  <= 1'b1;
              r_state <= S_DONE;
`endif
            end else begin
              r_region <= r_region + 5'd1;
            end
          end
          S_RD_CARD: if (wbm_resp.ack) begin
            r_req <= '0;
            if (wbm_resp.dat == 32'd0) begin
              r_state <= S_NEXT_WD;
            end else begin
              r_adr   <= w_card_adr;
              r_vld   <= 1'b1;
              r_word  <= w_pe_rest;
              r_state <= S_EMIT;
            end
          end
          S_EMIT: if (card_rdy_i) begin
            // r_word holds only bits not yet presented, so the next address is ready at once.
            if (r_word != 32'd0) begin
              r_adr  <= w_card_adr;
              r_word <= w_pe_rest;
            end else begin
              r_vld <= 1'b0;
`ifdef CARD_SCAN_CLEAR_EN
              r_req   <= bus_wr(card_word_adr(r_region, r_wd));
              r_state <= S_CLR_CARD;
`else
              r_state <= S_NEXT_WD;
`endif
            end
          end
`ifdef CARD_SCAN_CLEAR_EN
          S_CLR_CARD: if (wbm_resp.ack) begin
            r_req   <= '0;
            r_state <= S_NEXT_WD;
          end
          S_CLR_MCT: if (wbm_resp.ack) begin
            r_req   <= '0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
`endif
          S_NEXT_WD: begin
            if (r_wd == 5'd31) begin
              r_wd <= '0;
              if (r_region == 5'd31) begin
`ifdef CARD_SCAN_CLEAR_EN
                r_req   <= bus_wr(MCT_ADDR);
                r_state <= S_CLR_MCT;
`else
                r_done  <= 1'b1;
                r_state <= S_DONE;
`endif
              end else begin
                r_region <= r_region + 5'd1;
                r_state  <= S_NEXT_REG;
              end
            end else begin
              r_wd    <= r_wd + 5'd1;
              r_req   <= bus_rd(card_word_adr(r_region, r_wd + 5'd1));
              r_state <= S_RD_CARD;
            end
          end
          S_DONE: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign err_o      = r_err;
  assign wbm_req    = r_req;
  assign card_adr_o = r_adr;
  assign card_vld_o = r_vld;
endmodule

// File: tb/tb_card_table_scanner.sv
// Directed bench for card_table_scanner with a Wishbone memory slave and stream monitor.
module tb_card_table_scanner;
  import wb32_pkg::*;
  localparam logic [31:0] MCT_A  = 32'hFEE80000;
  localparam logic [31:0] CARD_A = 32'hFEE00000;
  localparam int TMO = 1023;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, rdy = 1'b1;
  logic busy, done, err, vld;
  logic [31:0] adr;
  wb_cmd_request32_t  wbm_req;
  wb_cmd_response32_t wbm_resp;

  always #5 clk = ~clk;

  card_table_scanner dut (
    .rst_i(rst), .clk_i(clk), .start_i(start), .busy_o(busy), .done_o(done), .err_o(err),
    .wbm_req(wbm_req), .wbm_resp(wbm_resp), .card_adr_o(adr), .card_vld_o(vld),
    .card_rdy_i(rdy));

  // Slave memory: index 0..1023 = card words {region,wd}, 1024 = master card table.
  logic [31:0] mem [0:1024];
  logic s_ack = 1'b0, s_err = 1'b0, ack_en = 1'b1, err_mode = 1'b0;
  logic [31:0] s_dat = '0;
  logic pl_we = 1'b0, pl_clr = 1'b0;
  int pl_idx = 0;
  logic [31:0] pl_val = '0;
  assign wbm_resp = '{ack: s_ack, err: s_err, dat: s_dat};

  function automatic int dec(input logic [31:0] a);
    if (a == MCT_A) return 1024;
    if (a[31:12] == CARD_A[31:12]) return int'(a[11:2]);
    return -1;
  endfunction

  always @(posedge clk) begin
    int idx;
    s_ack <= 1'b0;
    s_err <= 1'b0;
    if (pl_clr) begin
      for (int i = 0; i <= 1024; i++) mem[i] <= '0;
    end else if (pl_we) begin
      mem[pl_idx] <= pl_val;
    end
    if (wbm_req.cyc && wbm_req.stb && !s_ack && !s_err) begin
      idx = dec(wbm_req.padr);
      if (err_mode) s_err <= 1'b1;
      else if (ack_en) begin
        s_ack <= 1'b1;
        if (wbm_req.we) begin
          if (idx >= 0) mem[idx] <= wbm_req.dat;
        end else begin
          s_dat <= (idx >= 0) ? mem[idx] : 32'hDEADBEEF;
        end
      end
    end
  end

  int n_txn = 0, n_store = 0, n_storeptr = 0, n_done = 0, n_unstable = 0;
  logic [31:0] got_q[$];
  logic prev_hold = 1'b0, prev_wait = 1'b0;
  logic [31:0] prev_adr = '0, prev_padr = '0;

  always @(posedge clk) begin
    if (rst) begin
      prev_hold <= 1'b0;
      prev_wait <= 1'b0;
    end else begin
      if (wbm_req.cyc && s_ack) begin
        n_txn++;
        if (wbm_req.we) n_store++;
      end
      if (wbm_req.cyc && wbm_req.cmd == CMD_STOREPTR) n_storeptr++;
      if (vld && rdy) got_q.push_back(adr);
      if (done) n_done++;
      if (prev_hold && (!vld || adr != prev_adr)) n_unstable++;
      if (prev_wait && (!wbm_req.cyc || wbm_req.padr != prev_padr)) n_unstable++;
      prev_hold <= vld && !rdy;
      prev_adr  <= adr;
      prev_wait <= wbm_req.cyc && !s_ack && !s_err;
      prev_padr <= wbm_req.padr;
    end
  end

  int total = 0, bad = 0;
  int b_txn, b_store, b_done, b_unst, b_got;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    pl_idx = idx; pl_val = val; pl_we = 1'b1;
    tick();
    pl_we = 1'b0;
  endtask

  task automatic clear_mem();
    pl_clr = 1'b1;
    tick();
    pl_clr = 1'b0;
  endtask

  task automatic snap();
    b_txn = n_txn; b_store = n_store; b_done = n_done; b_unst = n_unstable; b_got = got_q.size();
  endtask

  // Pulses start, optionally re-pulses it at cycle restart_at, waits (bounded) for done_o.
  task automatic run_scan(input int limit, input int restart_at, input bit toggle, output int n);
    start = 1'b1;
    n = 0;
    for (int k = 1; k <= limit; k++) begin
      tick();
      start = (k == restart_at);
      if (toggle) rdy = k[0];
      if (done) begin n = k; break; end
    end
    start = 1'b0;
    total++;
    if (n == 0) begin bad++; $display("FAIL scan_bound: done_o not seen within %0d cycles", limit); end
    for (int k = 0; k < 6; k++) tick();
    rdy = 1'b1;
    tick();
  endtask

  task automatic scene_two();
    clear_mem();
    preload(1024, 32'h0000_0004);
    preload(64, 32'h8000_0001);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", err); end
    total++; if (vld !== 1'b0) begin bad++; $display("FAIL rst_vld: got %b want 0", vld); end
    total++; if (adr !== 32'h0) begin bad++; $display("FAIL rst_adr: got %h want 0", adr); end
    total++; if (wbm_req !== '0) begin bad++; $display("FAIL rst_req: got %h want 0", wbm_req); end
    rst = 1'b0;
    tick();
    $display("reset: busy=%b vld=%b cyc=%b", busy, vld, wbm_req.cyc);
  endtask

  task automatic test_mct_zero();
    int n;
    clear_mem();
    snap();
    run_scan(50, 0, 1'b0, n);
    $display("mct_zero: done after %0d clks, txn=%0d", n, n_txn - b_txn);
    total++; if (n < 3 || n > 6) begin bad++; $display("FAIL mct0_latency: got %0d want 3..6", n); end
    total++; if (n_txn - b_txn !== 1) begin bad++; $display("FAIL mct0_txn: got %0d want 1", n_txn - b_txn); end
    total++; if (got_q.size() - b_got !== 0) begin bad++; $display("FAIL mct0_addrs: got %0d want 0", got_q.size() - b_got); end
    total++; if (n_done - b_done !== 1) begin bad++; $display("FAIL mct0_done: got %0d want 1", n_done - b_done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mct0_busy: got %b want 0", busy); end
  endtask

  task automatic test_two_cards(input bit toggle);
    int n;
    logic [31:0] exp [2];
    exp[0] = 32'h0200_0000; exp[1] = 32'h0207_C000;
    scene_two();
    snap();
    run_scan(3000, 4, toggle, n);
    $display("two_cards toggle=%0d: %0d addrs, done=%0d, txn=%0d", toggle, got_q.size() - b_got,
             n_done - b_done, n_txn - b_txn);
    total++; if (got_q.size() - b_got !== 2) begin bad++; $display("FAIL two_count: got %0d want 2", got_q.size() - b_got); end
    for (int i = 0; i < 2 && b_got + i < got_q.size(); i++) begin
      total++;
      if (got_q[b_got + i] !== exp[i]) begin bad++; $display("FAIL two_addr%0d: got %h want %h", i, got_q[b_got + i], exp[i]); end
    end
    total++; if (n_done - b_done !== 1) begin bad++; $display("FAIL two_done: got %0d want 1", n_done - b_done); end
    total++; if (n_unstable - b_unst !== 0) begin bad++; $display("FAIL two_stable: got %0d want 0", n_unstable - b_unst); end
    total++; if (n_storeptr !== 0) begin bad++; $display("FAIL two_storeptr: got %0d want 0", n_storeptr); end
`ifdef CARD_SCAN_CLEAR_EN
    total++; if (n_txn - b_txn !== 35) begin bad++; $display("FAIL two_txn: got %0d want 35", n_txn - b_txn); end
    total++; if (mem[64] !== 32'h0) begin bad++; $display("FAIL clr_card: got %h want 0", mem[64]); end
    total++; if (mem[1024] !== 32'h0) begin bad++; $display("FAIL clr_mct: got %h want 0", mem[1024]); end
`else
    total++; if (n_txn - b_txn !== 33) begin bad++; $display("FAIL two_txn: got %0d want 33", n_txn - b_txn); end
    total++; if (n_store - b_store !== 0) begin bad++; $display("FAIL two_store: got %0d want 0", n_store - b_store); end
    total++; if (mem[64] !== 32'h8000_0001) begin bad++; $display("FAIL keep_card: got %h want 80000001", mem[64]); end
`endif
  endtask

  task automatic test_multi_region();
    int n;
    logic [31:0] exp [5];
    exp[0] = 32'h00F9_0000; exp[1] = 32'h0200_0000; exp[2] = 32'h0207_C000;
    exp[3] = 32'h1F28_4000; exp[4] = 32'h1F28_8000;
    clear_mem();
    preload(1024, 32'h8000_0005);
    preload(31, 32'h0000_0010);
    preload(64, 32'h8000_0001);
    preload(32, 32'hFFFF_FFFF);
    preload(31 * 32 + 5, 32'h0000_0006);
    snap();
    run_scan(5000, 0, 1'b0, n);
    $display("multi_region: %0d addrs, txn=%0d", got_q.size() - b_got, n_txn - b_txn);
    total++; if (got_q.size() - b_got !== 5) begin bad++; $display("FAIL multi_count: got %0d want 5", got_q.size() - b_got); end
    for (int i = 0; i < 5 && b_got + i < got_q.size(); i++) begin
      total++;
      if (got_q[b_got + i] !== exp[i]) begin bad++; $display("FAIL multi_addr%0d: got %h want %h", i, got_q[b_got + i], exp[i]); end
    end
`ifdef CARD_SCAN_CLEAR_EN
    total++; if (mem[32] !== 32'hFFFF_FFFF) begin bad++; $display("FAIL multi_unmarked: got %h want ffffffff", mem[32]); end
    snap();
    run_scan(50, 0, 1'b0, n);
    total++; if (got_q.size() - b_got !== 0) begin bad++; $display("FAIL rescan_addrs: got %0d want 0", got_q.size() - b_got); end
`else
    total++; if (n_txn - b_txn !== 97) begin bad++; $display("FAIL multi_txn: got %0d want 97", n_txn - b_txn); end
`endif
  endtask

  task automatic test_timeout();
    int n = 0;
    clear_mem();
    ack_en = 1'b0;
    start = 1'b1;
    for (int k = 1; k <= TMO + 100; k++) begin
      tick();
      start = 1'b0;
      if (err) begin n = k; break; end
    end
    $display("timeout: err after %0d clks, done=%b cyc=%b", n, done, wbm_req.cyc);
    total++; if (n !== TMO + 1) begin bad++; $display("FAIL tmo_latency: got %0d want %0d", n, TMO + 1); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL tmo_done: got %b want 1", done); end
    total++; if (wbm_req.cyc !== 1'b0) begin bad++; $display("FAIL tmo_cyc: got %b want 0", wbm_req.cyc); end
    ack_en = 1'b1;
    repeat (4) tick();
    run_scan(50, 0, 1'b0, n);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL tmo_err_clear: got %b want 0", err); end
  endtask

  task automatic test_bus_err();
    int n = 0;
    err_mode = 1'b1;
    start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      start = 1'b0;
      if (done) begin n = k; break; end
    end
    err_mode = 1'b0;
    $display("bus_err: done after %0d clks, err=%b", n, err);
    total++; if (err !== 1'b1 || n == 0) begin bad++; $display("FAIL buserr_flag: got err=%b n=%0d want err=1", err, n); end
    repeat (3) tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL buserr_busy: got %b want 0", busy); end
  endtask

  task automatic test_reset_emit();
    int n = 0;
    logic [31:0] exp [2];
    exp[0] = 32'h0200_0000; exp[1] = 32'h0207_C000;
    scene_two();
    rdy = 1'b0;
    start = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      tick();
      start = 1'b0;
      if (vld) begin n = k; break; end
    end
    total++; if (n == 0) begin bad++; $display("FAIL remit_reach: got vld=%b want 1 within 200 clks", vld); end
    rst = 1'b1;
    tick();
    $display("reset_emit: busy=%b vld=%b cyc=%b", busy, vld, wbm_req.cyc);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL remit_busy: got %b want 0", busy); end
    total++; if (vld !== 1'b0) begin bad++; $display("FAIL remit_vld: got %b want 0", vld); end
    total++; if (wbm_req.cyc !== 1'b0) begin bad++; $display("FAIL remit_cyc: got %b want 0", wbm_req.cyc); end
    rst = 1'b0;
    rdy = 1'b1;
    tick();
    snap();
    run_scan(3000, 0, 1'b0, n);
    total++; if (got_q.size() - b_got !== 2) begin bad++; $display("FAIL remit_count: got %0d want 2", got_q.size() - b_got); end
    for (int i = 0; i < 2 && b_got + i < got_q.size(); i++) begin
      total++;
      if (got_q[b_got + i] !== exp[i]) begin bad++; $display("FAIL remit_addr%0d: got %h want %h", i, got_q[b_got + i], exp[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_mct_zero();
    test_two_cards(1'b0);
    test_two_cards(1'b1);
    test_multi_region();
    test_timeout();
    test_bus_err();
    test_reset_emit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
